// File: rtl/pmod_pkg.sv
// Shared pmod definitions: default bus widths and the arbiter state encoding,
// reused by the command and bus-interface blocks.
package pmod_pkg;

    localparam int PMOD_ADDR_W = 32;
    localparam int PMOD_DATA_W = 64;
    localparam int PMOD_LEN_W  = 10;

    // IDLE: engine free; OWN0/OWN1: requester owns the engine;
    // REL: owner let go, waiting for the engine to drain.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        REL  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/pmod_rr_pick.sv
// Two-way round-robin pick: chooses which requesting lock wins, favouring the
// requester that was not served last when both ask at once.
module pmod_rr_pick (
    input  logic lock0,
    input  logic lock1,
    input  logic last,       // index of the requester served last
    output logic pick_valid, // at least one requester is asking
    output logic pick        // index of the winner
);

    // Tie goes to the requester opposite the last-served one.
    always_comb begin
        pick_valid = lock0 | lock1;
        pick       = 1'b0;
        if (lock0 && lock1) begin
            pick = ~last;
        end else if (lock1) begin
            pick = 1'b1;
        end
    end

endmodule

// File: rtl/pmod_bus_arb.sv
// Bus-master engine arbiter for two requesters. A registered FSM grants the
// engine to one lock holder at a time; the owner's command/data path is muxed
// straight through to the engine, everything else is forced to zero.
//
// Handshake: rN_lock is a level request. rN_gnt rises the cycle after the lock
// is sampled in IDLE and stays up while the lock is held (no preemption).
// Strobes are single-cycle pulses forwarded only while gnt=1 and lock=1; a
// strobe from a requester without gnt is dropped and latches err_drop.
module pmod_bus_arb
    import pmod_pkg::*;
#(
    parameter int ADDR_W = PMOD_ADDR_W,
    parameter int DATA_W = PMOD_DATA_W,
    parameter int LEN_W  = PMOD_LEN_W
) (
    input  logic              M_AXI_ACLK,
    input  logic              M_AXI_ARESETN,
    // requester 0
    input  logic              r0_lock,
    output logic              r0_gnt,
    input  logic              r0_write_req,
    input  logic              r0_write_bus_req,
    input  logic              r0_read_bus_req,
    input  logic              r0_read_req,
    input  logic [LEN_W-1:0]  r0_len,
    input  logic [ADDR_W-1:0] r0_address,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_busy,
    // requester 1
    input  logic              r1_lock,
    output logic              r1_gnt,
    input  logic              r1_write_req,
    input  logic              r1_write_bus_req,
    input  logic              r1_read_bus_req,
    input  logic              r1_read_req,
    input  logic [LEN_W-1:0]  r1_len,
    input  logic [ADDR_W-1:0] r1_address,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_busy,
    // engine side
    output logic              write_req,
    output logic              write_bus_req,
    output logic              read_bus_req,
    output logic              read_req,
    output logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              busy,
    // status / debug
    output logic              err_drop,
    output arb_state_t        dbg_state
);

    arb_state_t state, state_nxt;
    logic       last, last_nxt;
    logic       pick_valid, pick;
    logic       r0_any, r1_any, drop_hit;

    pmod_rr_pick u_pick (
        .lock0      (r0_lock),
        .lock1      (r1_lock),
        .last       (last),
        .pick_valid (pick_valid),
        .pick       (pick)
    );

    // State, last-served pointer and sticky drop flag; reset abandons ownership.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state    <= IDLE;
            last     <= 1'b1;
            err_drop <= 1'b0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            err_drop <= err_drop | drop_hit;
        end
    end

    // Next state: grant from IDLE, release on lock drop, drain in REL.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: if (pick_valid) begin
                state_nxt = pick ? OWN1 : OWN0;
                last_nxt  = pick;
            end
            OWN0: if (!r0_lock) state_nxt = REL;
            OWN1: if (!r1_lock) state_nxt = REL;
            REL:  if (!busy)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Owner mux toward the engine; strobes also need the owner's lock held.
    always_comb begin
        r0_gnt        = (state == OWN0);
        r1_gnt        = (state == OWN1);
        write_req     = 1'b0;
        write_bus_req = 1'b0;
        read_bus_req  = 1'b0;
        read_req      = 1'b0;
        len           = '0;
        address       = '0;
        wdata         = '0;
        if (r0_gnt) begin
            len     = r0_len;
            address = r0_address;
            wdata   = r0_wdata;
            if (r0_lock) begin
                write_req     = r0_write_req;
                write_bus_req = r0_write_bus_req;
                read_bus_req  = r0_read_bus_req;
                read_req      = r0_read_req;
            end
        end else if (r1_gnt) begin
            len     = r1_len;
            address = r1_address;
            wdata   = r1_wdata;
            if (r1_lock) begin
                write_req     = r1_write_req;
                write_bus_req = r1_write_bus_req;
                read_bus_req  = r1_read_bus_req;
                read_req      = r1_read_req;
            end
        end
    end

    // Per-requester views of the engine and detection of dropped strobes.
    always_comb begin
        r0_rdata = rdata;
        r1_rdata = rdata;
        r0_busy  = r0_gnt ? busy : 1'b1;
        r1_busy  = r1_gnt ? busy : 1'b1;
        r0_any   = r0_write_req | r0_write_bus_req | r0_read_bus_req | r0_read_req;
        r1_any   = r1_write_req | r1_write_bus_req | r1_read_bus_req | r1_read_req;
        drop_hit = (r0_any & ~r0_gnt) | (r1_any & ~r1_gnt);
    end

    assign dbg_state = state;

endmodule

// File: doc/pmod_bus_arb.md
PMOD_BUS_ARB -- requirements
Module: pmod_bus_arb

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_W, 32, address width.
- DATA_W, 64, data beat width.
- LEN_W, 10, transfer length width.

REQ-002 Ports, one per line: name, direction, width, meaning.
- M_AXI_ACLK, in, 1, sole clock. One clock; reset is asynchronous and active-low.
- M_AXI_ARESETN, in, 1, asynchronous active-low reset.
- rN_lock, in, 1, requester N (N=0,1) wants or holds the bus-master engine (level).
- rN_gnt, out, 1, requester N owns the engine.
- rN_write_req, in, 1, write data beat strobe.
- rN_write_bus_req, in, 1, start write burst strobe.
- rN_read_bus_req, in, 1, start read burst strobe.
- rN_read_req, in, 1, read data pop strobe.
- rN_len, in, LEN_W, transfer length.
- rN_address, in, ADDR_W, byte address.
- rN_wdata, in, DATA_W, write beat.
- rN_rdata, out, DATA_W, read beat.
- rN_busy, out, 1, engine busy as seen by N.
- write_req, write_bus_req, read_bus_req, read_req, out, 1 each, strobes to engine.
- len, address, wdata, out, LEN_W/ADDR_W/DATA_W, to engine.
- rdata, in, DATA_W, from engine.
- busy, in, 1, engine transaction in flight.
- err_drop, out, 1, sticky: a non-owner strobe was dropped.

Function
REQ-003 The FSM SHALL have four states: IDLE, OWN0, OWN1, REL.
- IDLE->OWNn when rn_lock=1.
- OWNn->REL when rn_lock=0.
- REL->IDLE when busy=0.
REQ-004 The FSM SHALL be registered: grant SHALL assert in the cycle after lock is sampled in IDLE. rN_gnt=1 exactly in state OWNN.
REQ-005 Round-robin: if both locks are 1 in IDLE, the grant SHALL go to the requester not served last. The last-served pointer SHALL reset to 1, so r0 wins the first tie.
REQ-006 After an owner releases, the FSM SHALL spend at least one cycle in IDLE before the next grant (minimum 2-cycle gap: REL then IDLE).
REQ-007 In OWNN, requester N's strobes, len, address and wdata SHALL pass combinationally to the engine. In every other state, strobes SHALL be 0 and len/address/wdata SHALL be 0.
REQ-008 Strobes from the owner in the cycle its lock is 0 SHALL be dropped.
REQ-009 rdata SHALL fan out to both rN_rdata unmodified.
REQ-010 rN_busy SHALL be busy when rN_gnt=1, else 1.
REQ-011 Any strobe from a requester without gnt SHALL be dropped and SHALL set err_drop. err_drop SHALL clear only on reset.
REQ-012 If lock falls while busy=1, the FSM SHALL hold in REL with no strobes forwarded until busy=0. If busy=0 in the REL cycle, the FSM SHALL return to IDLE next cycle.
REQ-013 A lock asserted by the non-owner SHALL wait. A lock held after being granted SHALL never be preempted.

Reset
REQ-014 Asynchronous assertion SHALL force: state IDLE, last pointer=1, err_drop=0, rN_gnt=0, all engine strobes=0, len/address/wdata=0, rN_busy=1. Release SHALL be synchronous to M_AXI_ACLK.
REQ-015 Reset mid-transaction SHALL abandon ownership without completing the burst. The engine is reset by the same signal.

Structure
REQ-016 FSM state encoding and the ADDR_W/DATA_W/LEN_W defaults SHALL live in the shared pmod package, for reuse by the command and bus-interface blocks.
REQ-017 There SHALL be one sub-module, pmod_rr_pick: 2-way round-robin selection from locks and the last-served pointer. All muxing SHALL stay in pmod_bus_arb.

Verification
REQ-018 Reset, then r0_lock=1 at cycle 0 -> r0_gnt=1 at cycle 1; r0_address=0x1000, len=4 appear on address/len; r1_busy=1.
REQ-019 Both locks rise in the same cycle after reset -> r0 granted. r0 releases with busy=0 -> REL, IDLE, then r1_gnt=1 exactly 3 cycles after r0_lock fell.
REQ-020 r1 owns; r1_lock falls while busy=1 for 5 cycles; r0_lock=1 -> r0_gnt stays 0 until 2 cycles after busy falls; no strobes forwarded meanwhile.
REQ-021 r0 owns; r1 pulses r1_write_req -> write_req stays 0, err_drop=1 and remains 1 until reset.
REQ-022 r0 owns with busy=1; M_AXI_ARESETN=0 asynchronously -> r0_gnt=0 and write_bus_req=0 in the same cycle. After release, r0 (lock still 1) is regranted one cycle later.
